p09_block_collider: RTL and testbench

P09_BLOCK_COLLIDER -- requirements
Module: p09_block_collider

---
 rtl/p09_block_collider.sv | 79 +++++++
 tb/tb_p09_block_collider.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/p09_block_collider.sv
// p09_block_collider: walks the block-state store to the queried row, clears a hit block and reports the result.
module p09_block_collider #(
  parameter int NUM_ROWS       = 15,
  parameter int INITIAL_BLOCKS = 91
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_row,
  input  logic [3:0]  req_col,
  output logic        resp_valid,
  output logic        resp_hit,
  input  logic        new_level,
  output logic [6:0]  blocks_left,
  output logic        level_clear,
  input  logic [12:0] line,
  output logic [12:0] new_line,
  output logic        write_line,
  output logic        next_line,
  output logic        reset_state
);
  typedef enum logic [1:0] {IDLE, SEEK, CHECK, DONE} state_t;
  localparam logic [3:0] LAST = 4'(NUM_ROWS - 1);
  localparam logic [4:0] ROWS = 5'(NUM_ROWS);
  localparam logic [6:0] INIT = 7'(INITIAL_BLOCKS);
  state_t state, state_nx;
  logic [3:0]  ptr, row_q, col_q;
  logic        hit, hit_q, in_range;
  logic [15:0] line_ext;
  assign line_ext    = {3'b000, line};
  assign in_range    = {1'b0, row_q} < ROWS;
  assign hit         = state == CHECK && in_range && col_q <= 4'd12 && line_ext[col_q];
  assign req_ready   = state == IDLE && !new_level;
  assign resp_valid  = state == DONE;
  assign resp_hit    = state == DONE && hit_q;
  assign level_clear = blocks_left == 7'd0;
  // An out-of-range row never moves the store; CHECK then reports a miss.
  always_comb begin
    state_nx    = state;
    next_line   = 1'b0;
    write_line  = 1'b0;
    reset_state = 1'b0;
    new_line    = '0;
    case (state)
      IDLE:  begin
        reset_state = new_level;
        state_nx    = (!new_level && req_valid) ? SEEK : IDLE;
      end
      SEEK:  begin
        next_line = in_range && ptr != row_q;
        state_nx  = next_line ? SEEK : CHECK;
      end
      CHECK: begin
        write_line = hit;
        new_line   = hit ? (line & ~(13'd1 << col_q)) : '0;
        state_nx   = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      ptr         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      hit_q       <= 1'b0;
      blocks_left <= INIT;
    end else begin
      state       <= state_nx;
      ptr         <= reset_state ? '0 : next_line ? (ptr == LAST ? '0 : ptr + 4'd1) : ptr;
      row_q       <= (req_valid && req_ready) ? req_row : row_q;
      col_q       <= (req_valid && req_ready) ? req_col : col_q;
      hit_q       <= state == CHECK ? hit : hit_q;
      blocks_left <= reset_state ? INIT : (write_line && blocks_left != 7'd0) ? blocks_left - 7'd1 : blocks_left;
    end
  end
endmodule

// File: tb/tb_p09_block_collider.sv
// tb_p09_block_collider: directed and random hit queries against a bitmap reference model, with a behavioural store.
module tb_p09_block_collider;
  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_row = '0;
  logic [3:0]  req_col = '0;
  logic        resp_valid, resp_hit;
  logic        new_level = 1'b0;
  logic [6:0]  blocks_left;
  logic        level_clear;
  logic [12:0] line, new_line;
  logic        write_line, next_line, reset_state;

  int tests = 0;
  int fails = 0;

  logic [12:0] store [15];
  int          sptr;
  logic [12:0] ref_map [15];
  int          ref_ptr, ref_left;

  p09_block_collider dut (
    .clk(clk), .nRst(nRst), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_col(req_col), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .new_level(new_level), .blocks_left(blocks_left), .level_clear(level_clear),
    .line(line), .new_line(new_line), .write_line(write_line), .next_line(next_line),
    .reset_state(reset_state)
  );

  always #5 clk = ~clk;

  // Initial level: rows 8..14 full, rows 0..7 empty (7 * 13 = 91 blocks).
  function automatic logic [12:0] init_row(input int r);
    return r >= 8 ? 13'h1FFF : 13'h0000;
  endfunction

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sptr <= 0;
      for (int i = 0; i < 15; i++) store[i] <= init_row(i);
    end else if (reset_state) begin
      sptr <= 0;
      for (int i = 0; i < 15; i++) store[i] <= init_row(i);
    end else if (next_line) sptr <= (sptr + 1) % 15;
    else if (write_line) store[sptr] <= new_line;
  end
  assign line = store[sptr];

  task automatic model_reset();
    for (int i = 0; i < 15; i++) ref_map[i] = init_row(i);
    ref_ptr  = 0;
    ref_left = 91;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Follows an accepted request until resp_valid and checks everything against the model.
  task automatic collect(input int r, input int c);
    int          lat, nl, wl, d;
    logic        h, exp_h;
    logic [12:0] nlv, exp_nlv;
    lat = -1; nl = 0; wl = 0; h = 1'bx; nlv = 'x;
    exp_h = 1'b0;
    if (r < 15 && c < 13) exp_h = ref_map[r][c];
    d = r < 15 ? (r - ref_ptr + 15) % 15 : 0;
    exp_nlv = exp_h ? (ref_map[r] & ~(13'd1 << c)) : 13'd0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      chk("strobe_excl", 32'($countones({write_line, next_line, reset_state}) <= 1), 1);
      chk("new_line_idle", 32'(!write_line && new_line != 13'd0), 0);
      nl += int'(next_line);
      if (write_line) begin wl++; nlv = new_line; end
      if (resp_valid) begin lat = cyc; h = resp_hit; break; end
    end
    chk("latency", lat, d + 3);
    chk("next_line_cnt", nl, d);
    chk("write_cnt", wl, int'(exp_h));
    if (exp_h) chk("new_line", 32'(nlv), 32'(exp_nlv));
    chk("resp_hit", 32'(h), 32'(exp_h));
    if (r < 15) ref_ptr = r;
    if (exp_h) begin ref_map[r] = exp_nlv; ref_left = ref_left > 0 ? ref_left - 1 : 0; end
    @(posedge clk); #1;
    chk("blocks_left", 32'(blocks_left), ref_left);
    chk("level_clear", 32'(level_clear), 32'(ref_left == 0));
  endtask

  task automatic issue(input int r, input int c);
    @(negedge clk);
    req_row = 4'(r); req_col = 4'(c); req_valid = 1'b1;
    chk("req_ready", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic query(input int r, input int c);
    issue(r, c);
    collect(r, c);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs"}, 32'({resp_valid, resp_hit, write_line, next_line, reset_state, level_clear}), 0);
    chk({tag, "_new_line"}, 32'(new_line), 0);
    chk({tag, "_blocks"}, 32'(blocks_left), 91);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #23;
    check_reset_outputs("rst");
    @(negedge clk); nRst = 1'b1;
    // Max-distance hit then repeated miss on the same position.
    query(14, 12);
    chk("bl_after_max", 32'(blocks_left), 90);
    query(14, 12);
    chk("bl_after_repeat", 32'(blocks_left), 90);
    // Wrap-around to empty row 0, then out-of-range column and row.
    query(0, 0);
    query(9, 13);
    query(15, 3);
    chk("bl_after_oor", 32'(blocks_left), 90);
    query(12, 4);
    // new_level beats a simultaneous request; the request lands a cycle later.
    @(negedge clk);
    new_level = 1'b1; req_valid = 1'b1; req_row = 4'd10; req_col = 4'd3;
    #1;
    chk("nl_ready", 32'(req_ready), 0);
    chk("nl_reset_state", 32'(reset_state), 1);
    @(posedge clk); #1;
    new_level = 1'b0;
    model_reset();
    @(negedge clk);
    chk("nl_blocks", 32'(blocks_left), 91);
    chk("nl_reset_once", 32'(reset_state), 0);
    chk("nl_ready_later", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    collect(10, 3);
    // Random queries, including out-of-range rows and columns.
    for (int i = 0; i < 40; i++) query(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
    // Clear every remaining block.
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 13; c++)
        if (ref_map[r][c]) query(r, c);
    chk("cleared_flag", 32'(level_clear), 1);
    chk("cleared_blocks", 32'(blocks_left), 0);
    query(9, 4);
    chk("cleared_stay", 32'(blocks_left), 0);
    // Reset while seeking aborts the request.
    issue((ref_ptr + 7) % 15, 0);
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    model_reset();
    begin
      int seen = 0;
      repeat (25) begin
        @(negedge clk);
        seen += int'(resp_valid);
      end
      chk("abort_no_resp", seen, 0);
    end
    query(8, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
